multicycle_ctrl: RTL and testbench

// Multicycle sequencer for the custom MIPS-subset datapath: and, nor, nori, not, rolv, rorv, lw, sw, bleu, jr, jal.

---
 rtl/multicycle_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle sequencer for the MIPS-subset datapath.
// A Moore FSM steps each instruction through fetch/decode/execute/memory/writeback.
// It handshakes with a variable-latency memory, with a bounded wait, and counts
// retired instructions. ir_write/pc_write in FETCH and pc_write in BRANCH also
// depend on the current inputs.
module multicycle_ctrl #(
    parameter int MEM_WAIT_MAX = 15,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      ins,
    input  logic             mem_ready,
    input  logic             bleu_taken,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             link,
    output logic             mem_to_reg,
    output logic             alu_src,
    output logic [2:0]       alu_op,
    output logic [3:0]       state,
    output logic             fault,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC     = 4'd2,
        ALU_WB   = 4'd3,
        MEM_ADDR = 4'd4,
        MEM_RD   = 4'd5,
        MEM_WB   = 4'd6,
        MEM_WR   = 4'd7,
        BRANCH   = 4'd8,
        JUMP     = 4'd9,
        FAULT    = 4'd15
    } state_e;

    localparam logic [5:0] OP_AND  = 6'b100000;
    localparam logic [5:0] OP_NOR  = 6'b100110;
    localparam logic [5:0] OP_NORI = 6'b001110;
    localparam logic [5:0] OP_NOT  = 6'b000100;
    localparam logic [5:0] OP_ROLV = 6'b000000;
    localparam logic [5:0] OP_RORV = 6'b000010;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BLEU = 6'b010000;
    localparam logic [5:0] OP_JR   = 6'b001000;
    localparam logic [5:0] OP_JAL  = 6'b000011;

    // The wait counter only needs to reach MEM_WAIT_MAX.
    localparam int             WAIT_W   = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MEM_WAIT_MAX);

    state_e             state_q, state_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]   instr_count_q, instr_count_d;
    logic [5:0]         opcode;
    logic               is_nori;
    logic               mem_wait;
    logic               retire;
    logic               unused_ins_bits;

    assign opcode          = ins[31:26];
    assign is_nori         = (opcode == OP_NORI);
    assign unused_ins_bits = ^ins[25:0];
    assign state           = state_q;
    assign instr_count     = instr_count_q;

    // State register, memory wait counter and retired-instruction counter.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (reset) begin
            state_q       <= FETCH;
            wait_cnt_q    <= '0;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            instr_count_q <= instr_count_d;
        end
    end

    // Next-state, datapath controls, timeout and retire decode.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        instr_count_d = instr_count_q;
        mem_wait      = 1'b0;
        retire        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_src        = 2'd0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        link          = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src       = 1'b0;
        alu_op        = 3'd0;
        fault         = 1'b0;

        case (state_q)
            FETCH: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = DECODE;
                end else begin
                    mem_wait = 1'b1;
                end
            end
            DECODE: begin
                case (opcode)
                    OP_AND, OP_NOR, OP_NORI,
                    OP_NOT, OP_ROLV, OP_RORV: state_d = EXEC;
                    OP_LW, OP_SW:             state_d = MEM_ADDR;
                    OP_BLEU:                  state_d = BRANCH;
                    OP_JR, OP_JAL:            state_d = JUMP;
                    default:                  state_d = FAULT;
                endcase
            end
            EXEC: begin
                case (opcode)
                    OP_NOR, OP_NORI, OP_NOT: alu_op = 3'd1;
                    OP_ROLV:                 alu_op = 3'd2;
                    OP_RORV:                 alu_op = 3'd3;
                    default:                 alu_op = 3'd0;
                endcase
                alu_src = is_nori;
                state_d = ALU_WB;
            end
            ALU_WB: begin
                reg_write = 1'b1;
                reg_dst   = !is_nori;
                retire    = 1'b1;
                state_d   = FETCH;
            end
            MEM_ADDR: begin
                alu_op  = 3'd4;
                alu_src = 1'b1;
                state_d = (opcode == OP_LW) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                mem_read = 1'b1;
                if (mem_ready) state_d = MEM_WB;
                else           mem_wait = 1'b1;
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                state_d    = FETCH;
            end
            MEM_WR: begin
                mem_write = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = FETCH;
                end else begin
                    mem_wait = 1'b1;
                end
            end
            BRANCH: begin
                alu_op   = 3'd5;
                pc_src   = 2'd1;
                pc_write = bleu_taken;
                retire   = 1'b1;
                state_d  = FETCH;
            end
            JUMP: begin
                pc_write = 1'b1;
                if (opcode == OP_JAL) begin
                    pc_src    = 2'd3;
                    reg_write = 1'b1;
                    link      = 1'b1;
                end else begin
                    pc_src = 2'd2;
                end
                retire  = 1'b1;
                state_d = FETCH;
            end
            FAULT: begin
                fault = 1'b1;
            end
            default: begin
                state_d = FAULT;
            end
        endcase

        // Memory timeout: a mem_ready on the limit cycle still completes normally.
        if (mem_wait && (MEM_WAIT_MAX != 0) && (wait_cnt_q == WAIT_LIM)) begin
            state_d = FAULT;
        end

        // Every state change restarts the wait count, which covers entry to each wait state.
        if (state_d != state_q) wait_cnt_d = '0;
        else if (mem_wait)      wait_cnt_d = wait_cnt_q + 1'b1;

        if (retire) instr_count_d = instr_count_q + 1'b1;
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: each driven cycle pushes the expected
// state/control/count record, which is popped and compared mid-cycle.
module tb_multicycle_ctrl;

    logic        clk;
    logic        reset;
    logic [31:0] ins;
    logic        mem_ready;
    logic        bleu_taken;
    logic        mem_read, mem_write, ir_write, pc_write;
    logic [1:0]  pc_src;
    logic        reg_write, reg_dst, link, mem_to_reg, alu_src;
    logic [2:0]  alu_op;
    logic [3:0]  state;
    logic        fault;
    logic [15:0] instr_count;

    // Narrow-counter instance used to exercise the counter wrap in a few instructions.
    logic        unused_mr, unused_mw, unused_irw, unused_pcw;
    logic [1:0]  unused_ps;
    logic        unused_rw, unused_rd, unused_lk, unused_m2r, unused_as;
    logic [2:0]  unused_aop;
    logic [3:0]  unused_st;
    logic        unused_flt;
    logic [2:0]  small_count;

    multicycle_ctrl #(.MEM_WAIT_MAX(15), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .ins(ins), .mem_ready(mem_ready), .bleu_taken(bleu_taken),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .pc_write(pc_write),
        .pc_src(pc_src), .reg_write(reg_write), .reg_dst(reg_dst), .link(link),
        .mem_to_reg(mem_to_reg), .alu_src(alu_src), .alu_op(alu_op), .state(state),
        .fault(fault), .instr_count(instr_count)
    );

    multicycle_ctrl #(.MEM_WAIT_MAX(15), .CNT_W(3)) dut_small (
        .clk(clk), .reset(reset), .ins(ins), .mem_ready(mem_ready), .bleu_taken(bleu_taken),
        .mem_read(unused_mr), .mem_write(unused_mw), .ir_write(unused_irw), .pc_write(unused_pcw),
        .pc_src(unused_ps), .reg_write(unused_rw), .reg_dst(unused_rd), .link(unused_lk),
        .mem_to_reg(unused_m2r), .alu_src(unused_as), .alu_op(unused_aop), .state(unused_st),
        .fault(unused_flt), .instr_count(small_count)
    );

    typedef struct packed {
        logic [3:0]  st;
        logic [14:0] c;
        logic [15:0] n;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts one comparison and reports it when observed differs from required.
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
        end
    endtask

    // Packs control outputs in the same order as the observed vector below.
    function automatic logic [14:0] ctl(input logic mr, input logic mw, input logic irw,
                                        input logic pcw, input logic [1:0] ps, input logic rw,
                                        input logic rdst, input logic lk, input logic m2r,
                                        input logic asrc, input logic [2:0] aop, input logic flt);
        return {mr, mw, irw, pcw, ps, rw, rdst, lk, m2r, asrc, aop, flt};
    endfunction

    // Drives one cycle's inputs, pushes its expectation and compares it mid-cycle.
    task automatic step(input logic rdy, input logic tkn, input exp_t e);
        exp_t        x;
        logic [34:0] obs;
        mem_ready  = rdy;
        bleu_taken = tkn;
        sb.push_back(e);
        @(negedge clk);
        x   = sb.pop_front();
        obs = {state, mem_read, mem_write, ir_write, pc_write, pc_src, reg_write, reg_dst,
               link, mem_to_reg, alu_src, alu_op, fault, instr_count};
        check($sformatf("state%0d_cycle", x.st), {29'd0, obs}, {29'd0, x});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        cnt   = '0;
    endtask

    // Expands one instruction into the cycle sequence the controller must produce.
    task automatic run_instr(input logic [31:0] i, input int waits, input logic tkn);
        logic [5:0]  op;
        logic        nori;
        logic [2:0]  aop;
        logic [14:0] z;
        z  = '0;
        op = i[31:26];
        ins = i;
        step(1'b1, 1'b0, {4'd0, ctl(1,0,1,1,2'd0,0,0,0,0,0,3'd0,0), cnt});
        step(1'b0, 1'b0, {4'd1, z, cnt});
        case (op)
            6'b100000, 6'b100110, 6'b001110, 6'b000100, 6'b000000, 6'b000010: begin
                nori = (op == 6'b001110);
                aop  = (op == 6'b100000) ? 3'd0 : (op == 6'b000000) ? 3'd2 :
                       (op == 6'b000010) ? 3'd3 : 3'd1;
                step(1'b0, 1'b0, {4'd2, ctl(0,0,0,0,2'd0,0,0,0,0,nori,aop,0), cnt});
                step(1'b0, 1'b0, {4'd3, ctl(0,0,0,0,2'd0,1,!nori,0,0,0,3'd0,0), cnt});
            end
            6'b100011: begin
                step(1'b0, 1'b0, {4'd4, ctl(0,0,0,0,2'd0,0,0,0,0,1,3'd4,0), cnt});
                for (int k = 0; k < waits; k++)
                    step(1'b0, 1'b0, {4'd5, ctl(1,0,0,0,2'd0,0,0,0,0,0,3'd0,0), cnt});
                step(1'b1, 1'b0, {4'd5, ctl(1,0,0,0,2'd0,0,0,0,0,0,3'd0,0), cnt});
                step(1'b0, 1'b0, {4'd6, ctl(0,0,0,0,2'd0,1,0,0,1,0,3'd0,0), cnt});
            end
            6'b101011: begin
                step(1'b0, 1'b0, {4'd4, ctl(0,0,0,0,2'd0,0,0,0,0,1,3'd4,0), cnt});
                for (int k = 0; k < waits; k++)
                    step(1'b0, 1'b0, {4'd7, ctl(0,1,0,0,2'd0,0,0,0,0,0,3'd0,0), cnt});
                step(1'b1, 1'b0, {4'd7, ctl(0,1,0,0,2'd0,0,0,0,0,0,3'd0,0), cnt});
            end
            6'b010000: step(1'b0, tkn, {4'd8, ctl(0,0,0,tkn,2'd1,0,0,0,0,0,3'd5,0), cnt});
            6'b001000: step(1'b0, 1'b0, {4'd9, ctl(0,0,0,1,2'd2,0,0,0,0,0,3'd0,0), cnt});
            6'b000011: step(1'b0, 1'b0, {4'd9, ctl(0,0,0,1,2'd3,1,0,1,0,0,3'd0,0), cnt});
            default: begin
                for (int k = 0; k < 3; k++)
                    step(k[0], 1'b0, {4'd15, ctl(0,0,0,0,2'd0,0,0,0,0,0,3'd0,1), cnt});
                return;
            end
        endcase
        cnt = cnt + 16'd1;
    endtask

    initial begin
        reset      = 1'b1;
        ins        = '0;
        mem_ready  = 1'b0;
        bleu_taken = 1'b0;
        cnt        = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("reset_state", {60'd0, state}, 64'd0);
        check("reset_fault", {63'd0, fault}, 64'd0);
        check("reset_count", {48'd0, instr_count}, 64'd0);
        @(posedge clk);
        #1;

        // ALU group, including low instruction bits that must be ignored.
        run_instr(32'h8000_0000, 0, 1'b0);
        run_instr(32'h9800_1234, 0, 1'b0);
        run_instr(32'h3800_00ff, 0, 1'b0);
        run_instr(32'h1000_0000, 0, 1'b0);
        run_instr(32'h0000_0000, 0, 1'b0);
        run_instr(32'h0800_a5a5, 0, 1'b0);
        // Loads/stores: stall of 3, zero wait, and ready on the last legal wait cycle.
        run_instr(32'h8C00_0000, 3, 1'b0);
        run_instr(32'h8C00_0004, 0, 1'b0);
        run_instr(32'h8C00_0008, 15, 1'b0);
        run_instr(32'hAC00_0000, 0, 1'b0);
        run_instr(32'hAC00_0010, 2, 1'b0);
        // Control transfers.
        run_instr(32'h4000_0000, 0, 1'b1);
        run_instr(32'h4000_0000, 0, 1'b0);
        run_instr(32'h0C00_0000, 0, 1'b0);
        run_instr(32'h2000_0000, 0, 1'b0);

        // Illegal opcode faults after DECODE and holds; reset recovers.
        run_instr(32'hFC00_0000, 0, 1'b0);
        do_reset();
        step(1'b1, 1'b0, {4'd0, ctl(1,0,1,1,2'd0,0,0,0,0,0,3'd0,0), cnt});
        step(1'b0, 1'b0, {4'd1, 15'd0, cnt});
        do_reset();

        // Fetch timeout: 16 FETCH cycles without mem_ready, then FAULT, even if ready appears.
        for (int k = 0; k < 16; k++)
            step(1'b0, 1'b0, {4'd0, ctl(1,0,0,0,2'd0,0,0,0,0,0,3'd0,0), cnt});
        step(1'b0, 1'b0, {4'd15, ctl(0,0,0,0,2'd0,0,0,0,0,0,3'd0,1), cnt});
        step(1'b1, 1'b0, {4'd15, ctl(0,0,0,0,2'd0,0,0,0,0,0,3'd0,1), cnt});
        do_reset();
        step(1'b0, 1'b0, {4'd0, ctl(1,0,0,0,2'd0,0,0,0,0,0,3'd0,0), cnt});
        do_reset();

        // Reset during MEM_WR with mem_ready high: store abandoned, not retired.
        run_instr(32'h8000_0000, 0, 1'b0);
        ins = 32'hAC00_0000;
        step(1'b1, 1'b0, {4'd0, ctl(1,0,1,1,2'd0,0,0,0,0,0,3'd0,0), cnt});
        step(1'b0, 1'b0, {4'd1, 15'd0, cnt});
        step(1'b0, 1'b0, {4'd4, ctl(0,0,0,0,2'd0,0,0,0,0,1,3'd4,0), cnt});
        step(1'b0, 1'b0, {4'd7, ctl(0,1,0,0,2'd0,0,0,0,0,0,3'd0,0), cnt});
        reset = 1'b1;
        step(1'b1, 1'b0, {4'd7, ctl(0,1,0,0,2'd0,0,0,0,0,0,3'd0,0), cnt});
        reset = 1'b0;
        cnt   = '0;
        step(1'b0, 1'b0, {4'd0, ctl(1,0,0,0,2'd0,0,0,0,0,0,3'd0,0), cnt});
        do_reset();

        // Counter wrap on the 3-bit instance: seven jr, then a retiring sw wraps to zero.
        for (int k = 0; k < 7; k++) run_instr(32'h2000_0000, 0, 1'b0);
        check("small_count_before_wrap", {61'd0, small_count}, 64'd7);
        run_instr(32'hAC00_0000, 0, 1'b0);
        check("small_count_wrapped", {61'd0, small_count}, 64'd0);
        check("main_count_after_wrap", {48'd0, instr_count}, {48'd0, cnt});

        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
